// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor: 2-bit counter encodings,
// allocation values, table entry layout and index/tag widths.
package bp_pkg;

  localparam int unsigned BP_ENTRIES = 16;
  localparam int unsigned BP_IDX_W   = 4;
  localparam int unsigned BP_TAG_W   = 32 - BP_IDX_W - 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e ALLOC_BR  = WT;
  localparam ctr_e ALLOC_JAL = ST;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [31:0]         target;
    ctr_e                ctr;
  } bp_entry_t;

  function automatic logic ctr_taken(input ctr_e c);
    return c[1];
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Combinational next state of a 2-bit saturating taken/not-taken counter.
module bp_sat_ctr
  import bp_pkg::*;
(
  input  ctr_e ctr,
  input  logic taken,
  output ctr_e ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      case (ctr)
        SNT:     ctr_next = WNT;
        WNT:     ctr_next = WT;
        WT:      ctr_next = ST;
        default: ctr_next = ST;
      endcase
    end else begin
      case (ctr)
        ST:      ctr_next = WT;
        WT:      ctr_next = WNT;
        WNT:     ctr_next = SNT;
        default: ctr_next = SNT;
      endcase
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BHT/BTB with zero-latency IF lookup, ID-stage branch/JAL
// resolution (mispredict + redirect), table training and perf counters.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = BP_ENTRIES,
  parameter int unsigned IDX_W   = BP_IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_if,
  output logic        pred_taken_if,
  output logic [31:0] pred_target_if,
  input  logic        id_valid,
  input  logic        id_is_branch,
  input  logic        id_is_jal,
  input  logic [31:0] id_pc,
  input  logic        id_pred_taken,
  input  logic [31:0] id_pred_target,
  input  logic        cmp_c,
  input  logic [31:0] id_target,
  input  logic        stall,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] miss_cnt
);

  // Entry tag field width comes from the package, so IDX_W must match BP_IDX_W.
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  bp_entry_t tbl [ENTRIES];

  logic [IDX_W-1:0] if_idx, id_idx;
  logic [TAG_W-1:0] if_tag, id_tag;
  logic             if_hit, id_hit;
  logic             act, res;
  ctr_e             ctr_upd;
  logic             unused_ok;

  assign if_idx = pc_if[IDX_W+1:2];
  assign if_tag = pc_if[31:IDX_W+2];
  assign id_idx = id_pc[IDX_W+1:2];
  assign id_tag = id_pc[31:IDX_W+2];
  assign unused_ok = ^{pc_if[1:0], id_pc[1:0]};

  assign if_hit = tbl[if_idx].valid && (tbl[if_idx].tag == if_tag);
  assign id_hit = tbl[id_idx].valid && (tbl[id_idx].tag == id_tag);

  always_comb begin
    pred_taken_if  = if_hit & ctr_taken(tbl[if_idx].ctr);
    pred_target_if = pred_taken_if ? tbl[if_idx].target : pc_if + 32'd4;
  end

  assign act         = id_is_jal | (id_is_branch & cmp_c);
  assign res         = id_valid & ~stall;
  assign redirect_pc = act ? id_target : id_pc + 32'd4;
  assign mispredict  = res & ((id_pred_taken != act) |
                              (act & (id_pred_target != id_target)));

  bp_sat_ctr u_sat (
    .ctr      (tbl[id_idx].ctr),
    .taken    (cmp_c),
    .ctr_next (ctr_upd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tbl[i[IDX_W-1:0]].valid  <= 1'b0;
        tbl[i[IDX_W-1:0]].tag    <= '0;
        tbl[i[IDX_W-1:0]].target <= '0;
        tbl[i[IDX_W-1:0]].ctr    <= WNT;
      end
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else if (res) begin
      // JAL wins when both decode flags are set.
      if (id_is_jal) begin
        tbl[id_idx] <= '{valid: 1'b1, tag: id_tag, target: id_target, ctr: ALLOC_JAL};
      end else if (id_is_branch) begin
        if (id_hit) begin
          tbl[id_idx].ctr <= ctr_upd;
          if (cmp_c) tbl[id_idx].target <= id_target;
        end else if (cmp_c) begin
          tbl[id_idx] <= '{valid: 1'b1, tag: id_tag, target: id_target, ctr: ALLOC_BR};
        end
      end else if (id_hit) begin
        tbl[id_idx].valid <= 1'b0;
      end
      if (id_is_branch | id_is_jal) branch_cnt <= branch_cnt + 32'd1;
      if (mispredict)               miss_cnt   <= miss_cnt + 32'd1;
    end
  end

endmodule
